// File: rtl/nmr_param_pkg.sv
// Shared types and default constants for the NMR parameter loader.
// The loader walks IDLE -> WR -> (RD -> RWAIT) -> IDLE for each command.
package nmr_param_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        RWAIT = 2'd3
    } state_t;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_VERIFY  = 1;
    localparam int DEF_TIMEOUT = 255;
    localparam int TMO_W       = 16;

    // Error counter holds at all-ones instead of wrapping back to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/nmr_param_timeout.sv
// Per-state stall counter: cleared on state entry, counts while enabled,
// flags expiry in the cycle the count reaches the configured limit.
module nmr_param_timeout
    import nmr_param_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [TMO_W-1:0] limit,
    output logic             expired
);

    logic [TMO_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable && (cnt != {TMO_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt == limit-1 means this cycle is the limit-th one spent in the state.
    assign expired = enable && !clear && (cnt == (limit - 1'b1));

endmodule

// File: rtl/nmr_param_loader.sv
// Writes one parameter word over Avalon-MM per command, optionally reads it
// back and compares under a mask, and reports done/err with a stall timeout.
module nmr_param_loader
    import nmr_param_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int VERIFY  = DEF_VERIFY,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [DATA_W-1:0] cmd_mask,

    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    output logic              avm_read,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    input  logic              avm_waitrequest,

    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       err_count,
    output logic [DATA_W-1:0] last_rdata,
    output logic [1:0]        state_dbg
);

    // Handshakes: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both 1; a bus request transfers on a rising edge where
    // avm_write or avm_read is 1 and avm_waitrequest is 0, with address and
    // data held constant until then; read data transfers on any edge with
    // avm_readdatavalid 1 while a read is outstanding.

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

    state_t            state;
    logic [DATA_W-1:0] mask_q;
    logic              wr_accept;
    logic              rd_accept;
    logic              rd_mismatch;
    logic              tmo_clear;
    logic              tmo_enable;
    logic              tmo_expired;

    assign wr_accept   = (state == WR) && !avm_waitrequest;
    assign rd_accept   = (state == RD) && !avm_waitrequest;
    assign rd_mismatch = |((avm_readdata ^ avm_writedata) & mask_q);

    // IDLE covers entry into WR; the two accept terms cover RD and RWAIT.
    assign tmo_clear  = (state == IDLE) || wr_accept || rd_accept;
    assign tmo_enable = (state != IDLE);

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    nmr_param_timeout u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .limit   (TMO_LIMIT),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cmd_ready     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
            avm_write     <= 1'b0;
            avm_read      <= 1'b0;
            mask_q        <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            err_count     <= '0;
            last_rdata    <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        avm_address   <= cmd_addr;
                        avm_writedata <= cmd_data;
                        mask_q        <= cmd_mask;
                        avm_write     <= 1'b1;
                        cmd_ready     <= 1'b0;
                        state         <= WR;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                WR: begin
                    if (wr_accept) begin
                        avm_write <= 1'b0;
                        if (VERIFY != 0) begin
                            avm_read <= 1'b1;
                            state    <= RD;
                        end else begin
                            done      <= 1'b1;
                            cmd_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end else if (tmo_expired) begin
                        avm_write <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        err_count <= sat_inc16(err_count);
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                RD: begin
                    if (rd_accept) begin
                        avm_read <= 1'b0;
                        // Zero-latency slaves return data with the accept.
                        if (avm_readdatavalid) begin
                            last_rdata <= avm_readdata;
                            done       <= 1'b1;
                            err        <= rd_mismatch;
                            if (rd_mismatch) begin
                                err_count <= sat_inc16(err_count);
                            end
                            cmd_ready  <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            state <= RWAIT;
                        end
                    end else if (tmo_expired) begin
                        avm_read  <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        err_count <= sat_inc16(err_count);
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                RWAIT: begin
                    if (avm_readdatavalid) begin
                        last_rdata <= avm_readdata;
                        done       <= 1'b1;
                        err        <= rd_mismatch;
                        if (rd_mismatch) begin
                            err_count <= sat_inc16(err_count);
                        end
                        cmd_ready  <= 1'b1;
                        state      <= IDLE;
                    end else if (tmo_expired) begin
                        done      <= 1'b1;
                        err       <= 1'b1;
                        err_count <= sat_inc16(err_count);
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    avm_write <= 1'b0;
                    avm_read  <= 1'b0;
                    cmd_ready <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nmr_param_loader.sv
// Directed bench for nmr_param_loader: a VERIFY=1/TIMEOUT=10 instance for the
// read-back paths and a VERIFY=0 instance for back-to-back writes.
module tb_nmr_param_loader;
    import nmr_param_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;
    logic [DW-1:0] cmd_mask = '0;
    logic [AW-1:0] avm_address;
    logic          avm_write, avm_read;
    logic [DW-1:0] avm_writedata;
    logic [DW-1:0] avm_readdata = '0;
    logic          avm_readdatavalid = 1'b0;
    logic          avm_waitrequest = 1'b0;
    logic          busy, done, err;
    logic [15:0]   err_count;
    logic [DW-1:0] last_rdata;
    logic [1:0]    state_dbg;

    logic          c0_cmd_valid = 1'b0;
    logic          c0_cmd_ready;
    logic [AW-1:0] c0_cmd_addr = '0;
    logic [DW-1:0] c0_cmd_data = '0;
    logic [DW-1:0] c0_cmd_mask = '0;
    logic [AW-1:0] c0_avm_address;
    logic          c0_avm_write, c0_avm_read;
    logic [DW-1:0] c0_avm_writedata;
    logic [DW-1:0] c0_avm_readdata = '0;
    logic          c0_avm_readdatavalid = 1'b0;
    logic          c0_avm_waitrequest = 1'b0;
    logic          c0_busy, c0_done, c0_err;
    logic [15:0]   c0_err_count;
    logic [DW-1:0] c0_last_rdata;
    logic [1:0]    c0_state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    nmr_param_loader #(.ADDR_W(AW), .DATA_W(DW), .VERIFY(1), .TIMEOUT(10)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_read(avm_read), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
        .busy(busy), .done(done), .err(err), .err_count(err_count),
        .last_rdata(last_rdata), .state_dbg(state_dbg)
    );

    nmr_param_loader #(.ADDR_W(AW), .DATA_W(DW), .VERIFY(0)) dut0 (
        .clk(clk), .reset(reset),
        .cmd_valid(c0_cmd_valid), .cmd_ready(c0_cmd_ready), .cmd_addr(c0_cmd_addr),
        .cmd_data(c0_cmd_data), .cmd_mask(c0_cmd_mask),
        .avm_address(c0_avm_address), .avm_write(c0_avm_write),
        .avm_writedata(c0_avm_writedata), .avm_read(c0_avm_read),
        .avm_readdata(c0_avm_readdata), .avm_readdatavalid(c0_avm_readdatavalid),
        .avm_waitrequest(c0_avm_waitrequest),
        .busy(c0_busy), .done(c0_done), .err(c0_err), .err_count(c0_err_count),
        .last_rdata(c0_last_rdata), .state_dbg(c0_state_dbg)
    );

    // Bus monitors: accepted writes, read/write overlap, VERIFY=0 write log.
    int wr_acc = 0;
    int rw_overlap = 0;
    int c0_rd_seen = 0;
    logic [AW+DW-1:0] c0_wr_q[$];
    logic [AW+DW-1:0] exp_q[$];

    always @(posedge clk) begin
        if (avm_write === 1'b1 && avm_waitrequest === 1'b0) wr_acc <= wr_acc + 1;
        if (avm_write === 1'b1 && avm_read === 1'b1) rw_overlap <= rw_overlap + 1;
        if (c0_avm_write === 1'b1 && c0_avm_waitrequest === 1'b0)
            c0_wr_q.push_back({c0_avm_address, c0_avm_writedata});
        if (c0_avm_read === 1'b1) c0_rd_seen <= c0_rd_seen + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one command to the VERIFY=1 instance with a zero-wait slave that
    // returns rdata one cycle after the read is accepted.
    task automatic run_cmd(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] m, input logic [DW-1:0] rdata,
                           output logic saw_done, output logic saw_err);
        logic rd_pending;
        rd_pending = 1'b0;
        saw_done = 1'b0;
        saw_err = 1'b0;
        avm_waitrequest = 1'b0;
        cmd_addr = a; cmd_data = d; cmd_mask = m; cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !saw_done; i++) begin
            if (rd_pending) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = rdata;
                rd_pending = 1'b0;
            end else begin
                avm_readdatavalid = 1'b0;
            end
            if (avm_read) rd_pending = 1'b1;
            tick;
            if (done) begin
                saw_done = 1'b1;
                saw_err = err;
            end
        end
        avm_readdatavalid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
        n_cmp++; if ({avm_write, avm_read} !== 2'b00) begin n_fail++; $display("FAIL reset_req: got %b want 00", {avm_write, avm_read}); end
        n_cmp++; if ({avm_address, avm_writedata} !== '0) begin n_fail++; $display("FAIL reset_bus: got %h/%h want 0", avm_address, avm_writedata); end
        n_cmp++; if ({busy, done, err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {busy, done, err}); end
        n_cmp++; if (err_count !== 16'd0 || last_rdata !== '0) begin n_fail++; $display("FAIL reset_regs: got %h/%h want 0", err_count, last_rdata); end
        reset = 1'b0;
        tick;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_rise: got %b want 1", cmd_ready); end
    endtask

    task automatic test_basic;
        avm_waitrequest = 1'b0;
        cmd_addr = 8'h00; cmd_data = 32'd16; cmd_mask = 32'hFFFF_FFFF; cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        n_cmp++; if ({avm_write, avm_address, avm_writedata} !== {1'b1, 8'h00, 32'd16}) begin n_fail++; $display("FAIL basic_wr: got %b %h %h want 1 00 00000010", avm_write, avm_address, avm_writedata); end
        n_cmp++; if ({cmd_ready, busy} !== 2'b01) begin n_fail++; $display("FAIL basic_busy: got %b want 01", {cmd_ready, busy}); end
        tick;
        n_cmp++; if ({avm_write, avm_read} !== 2'b01) begin n_fail++; $display("FAIL basic_rd: got %b want 01", {avm_write, avm_read}); end
        tick;
        n_cmp++; if ({avm_read, busy, done} !== 3'b010) begin n_fail++; $display("FAIL basic_rwait: got %b want 010", {avm_read, busy, done}); end
        avm_readdatavalid = 1'b1; avm_readdata = 32'd16;
        tick;
        avm_readdatavalid = 1'b0;
        n_cmp++; if ({done, err, cmd_ready, busy} !== 4'b1010) begin n_fail++; $display("FAIL basic_done: got %b want 1010", {done, err, cmd_ready, busy}); end
        n_cmp++; if (last_rdata !== 32'd16) begin n_fail++; $display("FAIL basic_rdata: got %h want 00000010", last_rdata); end
        tick;
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_wait_write;
        int base;
        int stable;
        base = wr_acc;
        stable = 0;
        avm_waitrequest = 1'b1;
        cmd_addr = 8'h5A; cmd_data = 32'hDEAD_BEEF; cmd_mask = 32'hFFFF_FFFF; cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        if (avm_write && avm_address == 8'h5A && avm_writedata == 32'hDEAD_BEEF && !avm_read) stable++;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (avm_write && avm_address == 8'h5A && avm_writedata == 32'hDEAD_BEEF && !avm_read) stable++;
        end
        n_cmp++; if (stable !== 4) begin n_fail++; $display("FAIL wait_stable_cycles: got %0d want 4", stable); end
        avm_waitrequest = 1'b0;
        tick;
        n_cmp++; if ({avm_write, avm_read, avm_address} !== {2'b01, 8'h5A}) begin n_fail++; $display("FAIL wait_to_rd: got %b %h want 01 5a", {avm_write, avm_read}, avm_address); end
        // Data returned together with the read accept: RWAIT is skipped.
        avm_readdatavalid = 1'b1; avm_readdata = 32'hDEAD_BEEF;
        tick;
        avm_readdatavalid = 1'b0;
        n_cmp++; if ({done, err, avm_read, busy} !== 4'b1000) begin n_fail++; $display("FAIL fast_rd_done: got %b want 1000", {done, err, avm_read, busy}); end
        n_cmp++; if (last_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL fast_rd_data: got %h want deadbeef", last_rdata); end
        n_cmp++; if (wr_acc - base !== 1) begin n_fail++; $display("FAIL wait_single_write: got %0d want 1", wr_acc - base); end
        tick;
    endtask

    task automatic test_mask;
        logic d, e;
        run_cmd(8'h21, 32'h0000_01FF, 32'h0000_00FF, 32'h0000_00FF, d, e);
        n_cmp++; if ({d, e} !== 2'b10) begin n_fail++; $display("FAIL mask_ff: got done/err %b want 10", {d, e}); end
        n_cmp++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL mask_ff_cnt: got %0d want 0", err_count); end
        tick;
        run_cmd(8'h22, 32'h0000_01FF, 32'h0000_01FF, 32'h0000_00FF, d, e);
        n_cmp++; if ({d, e} !== 2'b11) begin n_fail++; $display("FAIL mask_1ff: got done/err %b want 11", {d, e}); end
        n_cmp++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL mask_1ff_cnt: got %0d want 1", err_count); end
        n_cmp++; if (last_rdata !== 32'h0000_00FF) begin n_fail++; $display("FAIL mask_rdata: got %h want 000000ff", last_rdata); end
        tick;
    endtask

    task automatic test_timeout;
        int wcycles;
        logic d, e, st;
        wcycles = 0; d = 1'b0; e = 1'b0; st = 1'b1;
        avm_waitrequest = 1'b1;
        cmd_addr = 8'h40; cmd_data = 32'h1234_5678; cmd_mask = 32'hFFFF_FFFF; cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        if (avm_write) wcycles++;
        for (int i = 0; i < 30 && !d; i++) begin
            tick;
            if (avm_write) wcycles++;
            if (done) begin d = 1'b1; e = err; st = avm_write | avm_read | busy; end
        end
        avm_waitrequest = 1'b0;
        n_cmp++; if (wcycles !== 10) begin n_fail++; $display("FAIL tmo_write_cycles: got %0d want 10", wcycles); end
        n_cmp++; if ({d, e, st} !== 3'b110) begin n_fail++; $display("FAIL tmo_done_err_idle: got %b want 110", {d, e, st}); end
        n_cmp++; if (err_count !== 16'd2) begin n_fail++; $display("FAIL tmo_cnt: got %0d want 2", err_count); end
        tick;
    endtask

    task automatic test_reset_mid;
        logic d, e;
        avm_waitrequest = 1'b0;
        cmd_addr = 8'h30; cmd_data = 32'hAAAA_5555; cmd_mask = 32'hFFFF_FFFF; cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        tick; tick;
        n_cmp++; if ({busy, avm_read, avm_write} !== 3'b100) begin n_fail++; $display("FAIL mid_in_rwait: got %b want 100", {busy, avm_read, avm_write}); end
        reset = 1'b1;
        avm_readdatavalid = 1'b1; avm_readdata = 32'hAAAA_5555;
        tick;
        avm_readdatavalid = 1'b0;
        n_cmp++; if ({done, err, busy, cmd_ready, avm_write, avm_read} !== 6'b0) begin n_fail++; $display("FAIL mid_reset_flags: got %b want 000000", {done, err, busy, cmd_ready, avm_write, avm_read}); end
        n_cmp++; if ({err_count, last_rdata, avm_address, avm_writedata} !== '0) begin n_fail++; $display("FAIL mid_reset_regs: got %h %h %h %h want 0", err_count, last_rdata, avm_address, avm_writedata); end
        reset = 1'b0;
        tick;
        // Stray read data while idle must not be captured.
        avm_readdatavalid = 1'b1; avm_readdata = 32'hBAD0_BAD0;
        tick;
        avm_readdatavalid = 1'b0;
        n_cmp++; if ({last_rdata, done} !== {32'h0, 1'b0}) begin n_fail++; $display("FAIL stray_rdv: got %h %b want 0 0", last_rdata, done); end
        run_cmd(8'h33, 32'hCAFE_F00D, 32'hFFFF_FFFF, 32'hCAFE_F00D, d, e);
        n_cmp++; if ({d, e} !== 2'b10) begin n_fail++; $display("FAIL mid_after_cmd: got done/err %b want 10", {d, e}); end
        n_cmp++; if (last_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL mid_after_rdata: got %h want cafef00d", last_rdata); end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [AW-1:0] a_tab [3];
        logic [DW-1:0] d_tab [3];
        int idx, dones, rdy_bad, cycles;
        logic acc;
        a_tab = '{8'h10, 8'h11, 8'h12};
        d_tab = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
        for (int i = 0; i < 3; i++) exp_q.push_back({a_tab[i], d_tab[i]});
        c0_wr_q.delete();
        idx = 0; dones = 0; rdy_bad = 0; cycles = 0;
        c0_cmd_addr = a_tab[0]; c0_cmd_data = d_tab[0]; c0_cmd_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && dones < 3; cyc++) begin
            acc = c0_cmd_valid && c0_cmd_ready;
            tick;
            cycles++;
            if (c0_done) begin
                dones++;
                if (c0_cmd_ready !== 1'b1) rdy_bad++;
            end
            if (acc) begin
                idx++;
                if (idx < 3) begin c0_cmd_addr = a_tab[idx]; c0_cmd_data = d_tab[idx]; end
                else c0_cmd_valid = 1'b0;
            end
        end
        c0_cmd_valid = 1'b0;
        n_cmp++; if (dones !== 3) begin n_fail++; $display("FAIL b2b_dones: got %0d want 3", dones); end
        n_cmp++; if (cycles !== 6) begin n_fail++; $display("FAIL b2b_cycles: got %0d want 6", cycles); end
        n_cmp++; if (rdy_bad !== 0) begin n_fail++; $display("FAIL b2b_ready_in_done: got %0d bad want 0", rdy_bad); end
        n_cmp++; if (c0_wr_q.size() !== 3) begin n_fail++; $display("FAIL b2b_write_count: got %0d want 3", c0_wr_q.size()); end
        while (exp_q.size() > 0 && c0_wr_q.size() > 0) begin
            logic [AW+DW-1:0] got, want;
            got = c0_wr_q.pop_front();
            want = exp_q.pop_front();
            n_cmp++; if (got !== want) begin n_fail++; $display("FAIL b2b_write_data: got %h want %h", got, want); end
        end
        exp_q.delete();
        n_cmp++; if (c0_rd_seen !== 0) begin n_fail++; $display("FAIL b2b_no_read: got %0d reads want 0", c0_rd_seen); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_write();
        test_mask();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        n_cmp++; if (rw_overlap !== 0) begin n_fail++; $display("FAIL rw_exclusive: got %0d overlap cycles want 0", rw_overlap); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
